// File: rtl/cpu_pkg.sv
// Shared definitions for the pipelined RV32 core.
// Contents:
//   - opcode constants for the supported instruction classes
//   - ALUOp encodings produced by the main control decoder
//   - ctrl_t, the control bundle carried down the pipe, and CTRL_BUBBLE
//   - decode_ctrl(), the main control decoder truth table
package cpu_pkg;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   localparam logic [1:0] ALUOP_MEM = 2'b00;
   localparam logic [1:0] ALUOP_BEQ = 2'b01;
   localparam logic [1:0] ALUOP_R   = 2'b10;
   localparam logic [1:0] ALUOP_IMM = 2'b11;

   typedef struct packed {
      logic [1:0] alu_op;
      logic       alu_src;
      logic       reg_write;
      logic       mem_write;
      logic       mem_read;
      logic       mem2reg;
      logic       branch;
   } ctrl_t;

   localparam ctrl_t CTRL_BUBBLE = '0;

   // Main control decoder. Unknown opcodes decode to a bubble so they can
   // never write the register file or memory.
   function automatic ctrl_t decode_ctrl(input logic [6:0] opcode);
      ctrl_t c;
      c = CTRL_BUBBLE;
      case (opcode)
         OP_R: begin
            c.alu_op    = ALUOP_R;
            c.reg_write = 1'b1;
         end
         OP_IMM: begin
            c.alu_op    = ALUOP_IMM;
            c.alu_src   = 1'b1;
            c.reg_write = 1'b1;
         end
         OP_LOAD: begin
            c.alu_op    = ALUOP_MEM;
            c.alu_src   = 1'b1;
            c.reg_write = 1'b1;
            c.mem_read  = 1'b1;
            c.mem2reg   = 1'b1;
         end
         OP_STORE: begin
            c.alu_op    = ALUOP_MEM;
            c.alu_src   = 1'b1;
            c.mem_write = 1'b1;
         end
         OP_BRANCH: begin
            c.alu_op    = ALUOP_BEQ;
            c.branch    = 1'b1;
         end
         default: c = CTRL_BUBBLE;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detector (purely combinational).
// Flags a hazard when the instruction in ID reads the destination of a load
// that is currently sitting in EX.
// Ports:
//   id_valid            ID holds a real instruction
//   alu_src, mem_write  ID control bits, used to decide whether rs2 is read
//   rs1, rs2            ID source register addresses
//   ex_valid            EX holds a real instruction
//   ex_mem_read         EX instruction is a load
//   ex_rd               EX destination register
//   hazard              load-use hazard present
module hazard_detect (
   input  logic       id_valid,
   input  logic       alu_src,
   input  logic       mem_write,
   input  logic [4:0] rs1,
   input  logic [4:0] rs2,
   input  logic       ex_valid,
   input  logic       ex_mem_read,
   input  logic [4:0] ex_rd,
   output logic       hazard
);

   logic use_rs2;
   logic rs1_match;
   logic rs2_match;

   // rs2 is a real source for R-type and beq (register operand) and for
   // stores (store data). I-arith and loads put immediate bits in that field.
   assign use_rs2   = ~alu_src | mem_write;
   assign rs1_match = (ex_rd == rs1);
   assign rs2_match = use_rs2 & (ex_rd == rs2);

   // x0 is hard-wired to zero, so a load into it never produces a value
   // anyone has to wait for.
   assign hazard = id_valid & ex_valid & ex_mem_read & (ex_rd != 5'd0)
                 & (rs1_match | rs2_match);

endmodule

// File: rtl/id_ex_pipe.sv
// ID/EX pipeline register with load-use stall generation.
// Registers the decoder control bundle, operands, immediate, funct bits and
// register addresses for the EX stage, inserts bubbles on reset, flush and
// load-use hazards, and counts hazard bubbles.
// Ports:
//   clk_i, rst_i         clock, synchronous active-high reset
//   id_valid_i           ID holds a real instruction
//   alu_op_i .. branch_i control bundle from the main decoder
//   rs1_data_i .. pc_i   operand data, immediate, PC
//   funct_i              {funct7, funct3}, passed through untouched
//   rs1_i, rs2_i, rd_i   register addresses
//   flush_i              branch taken in EX, squash the ID instruction
//   hold_i               global freeze
//   stall_o              freeze PC and IF/ID (combinational)
//   ex_*_o               registered copies for the EX stage
//   bubble_cnt_o         saturating count of load-use bubbles
module id_ex_pipe
   import cpu_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int CNT_W = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             id_valid_i,
   input  logic [1:0]       alu_op_i,
   input  logic             alu_src_i,
   input  logic             reg_write_i,
   input  logic             mem_write_i,
   input  logic             mem_read_i,
   input  logic             mem2reg_i,
   input  logic             branch_i,
   input  logic [XLEN-1:0]  rs1_data_i,
   input  logic [XLEN-1:0]  rs2_data_i,
   input  logic [XLEN-1:0]  imm_i,
   input  logic [XLEN-1:0]  pc_i,
   input  logic [9:0]       funct_i,
   input  logic [4:0]       rs1_i,
   input  logic [4:0]       rs2_i,
   input  logic [4:0]       rd_i,
   input  logic             flush_i,
   input  logic             hold_i,
   output logic             stall_o,
   output logic             ex_valid_o,
   output logic [1:0]       ex_alu_op_o,
   output logic             ex_alu_src_o,
   output logic             ex_reg_write_o,
   output logic             ex_mem_write_o,
   output logic             ex_mem_read_o,
   output logic             ex_mem2reg_o,
   output logic             ex_branch_o,
   output logic [XLEN-1:0]  ex_rs1_data_o,
   output logic [XLEN-1:0]  ex_rs2_data_o,
   output logic [XLEN-1:0]  ex_imm_o,
   output logic [XLEN-1:0]  ex_pc_o,
   output logic [9:0]       ex_funct_o,
   output logic [4:0]       ex_rs1_o,
   output logic [4:0]       ex_rs2_o,
   output logic [4:0]       ex_rd_o,
   output logic [CNT_W-1:0] bubble_cnt_o
);

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   ctrl_t ctrl_in;
   ctrl_t ctrl_cap;
   ctrl_t ex_ctrl;
   logic  hazard;
   logic  bubble;

   always_comb begin
      ctrl_in.alu_op    = alu_op_i;
      ctrl_in.alu_src   = alu_src_i;
      ctrl_in.reg_write = reg_write_i;
      ctrl_in.mem_write = mem_write_i;
      ctrl_in.mem_read  = mem_read_i;
      ctrl_in.mem2reg   = mem2reg_i;
      ctrl_in.branch    = branch_i;
   end

   // An invalid ID slot still carries its data fields through, but its
   // control is zeroed so nothing downstream can write on its behalf.
   assign ctrl_cap = id_valid_i ? ctrl_in : CTRL_BUBBLE;

   hazard_detect u_hazard (
      .id_valid    (id_valid_i),
      .alu_src     (alu_src_i),
      .mem_write   (mem_write_i),
      .rs1         (rs1_i),
      .rs2         (rs2_i),
      .ex_valid    (ex_valid_o),
      .ex_mem_read (ex_mem_read_o),
      .ex_rd       (ex_rd_o),
      .hazard      (hazard)
   );

   // A taken branch squashes the consumer anyway, so stalling for it would
   // only waste a cycle. hold_i deliberately plays no part here.
   assign stall_o = hazard & ~flush_i;
   assign bubble  = flush_i | hazard;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ex_valid_o    <= 1'b0;
         ex_ctrl       <= CTRL_BUBBLE;
         ex_rs1_data_o <= '0;
         ex_rs2_data_o <= '0;
         ex_imm_o      <= '0;
         ex_pc_o       <= '0;
         ex_funct_o    <= '0;
         ex_rs1_o      <= '0;
         ex_rs2_o      <= '0;
         ex_rd_o       <= '0;
         bubble_cnt_o  <= '0;
      end else if (!hold_i) begin
         if (bubble) begin
            ex_valid_o    <= 1'b0;
            ex_ctrl       <= CTRL_BUBBLE;
            ex_rs1_data_o <= '0;
            ex_rs2_data_o <= '0;
            ex_imm_o      <= '0;
            ex_pc_o       <= '0;
            ex_funct_o    <= '0;
            ex_rs1_o      <= '0;
            ex_rs2_o      <= '0;
            ex_rd_o       <= '0;
            // Only hazard bubbles count; a flush takes precedence.
            if (!flush_i && bubble_cnt_o != CNT_MAX)
               bubble_cnt_o <= bubble_cnt_o + CNT_ONE;
         end else begin
            ex_valid_o    <= id_valid_i;
            ex_ctrl       <= ctrl_cap;
            ex_rs1_data_o <= rs1_data_i;
            ex_rs2_data_o <= rs2_data_i;
            ex_imm_o      <= imm_i;
            ex_pc_o       <= pc_i;
            ex_funct_o    <= funct_i;
            ex_rs1_o      <= rs1_i;
            ex_rs2_o      <= rs2_i;
            ex_rd_o       <= rd_i;
         end
      end
   end

   assign ex_alu_op_o    = ex_ctrl.alu_op;
   assign ex_alu_src_o   = ex_ctrl.alu_src;
   assign ex_reg_write_o = ex_ctrl.reg_write;
   assign ex_mem_write_o = ex_ctrl.mem_write;
   assign ex_mem_read_o  = ex_ctrl.mem_read;
   assign ex_mem2reg_o   = ex_ctrl.mem2reg;
   assign ex_branch_o    = ex_ctrl.branch;

endmodule
